// File: rtl/pinball_game_ctrl.sv
// Pinball game sequencer: serve/play/pause/ball-lost/game-over FSM with
// per-frame collision scoring, saturating score and ball accounting.
module pinball_game_ctrl #(
   parameter int BALLS_PER_GAME = 3,
   parameter int LOST_FRAMES    = 60,
   parameter int BONUS_POINTS   = 10,
   parameter int FLIPPER_POINTS = 1,
   parameter int SCORE_MAX      = 9999
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic        key5IsPressed,
   input  logic        keyPauseIsPressed,
   input  logic        collisionSmileyDrain,
   input  logic        collisionSmileyBonus,
   input  logic        collisionSmileyFlipper,
   output logic        pause,
   output logic        ballRestart,
   output logic        launch,
   output logic [1:0]  ballsLeft,
   output logic [13:0] score,
   output logic        gameOver,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SERVE     = 3'd1,
      ST_PLAY      = 3'd2,
      ST_PAUSED    = 3'd3,
      ST_BALL_LOST = 3'd4,
      ST_GAME_OVER = 3'd5
   } state_e;

   localparam logic [1:0]  BALLS_W   = 2'(BALLS_PER_GAME);
   localparam logic [5:0]  LOST_W    = 6'(LOST_FRAMES);
   localparam logic [15:0] BONUS_W   = 16'(BONUS_POINTS);
   localparam logic [15:0] FLIPPER_W = 16'(FLIPPER_POINTS);
   localparam logic [15:0] SMAX_W    = 16'(SCORE_MAX);

   state_e      state_q, state_d;
   logic        key5_prev_q, keyp_prev_q;
   logic        drain_q, drain_d, bonus_q, bonus_d, flip_q, flip_d;
   logic        pause_q, pause_d, restart_q, restart_d, launch_q, launch_d;
   logic        gameover_q, gameover_d;
   logic [1:0]  balls_q, balls_d;
   logic [13:0] score_q, score_d;
   logic [5:0]  timer_q, timer_d;
   logic        key5_edge_s, keyp_edge_s;
   logic [15:0] score_sum_s;

   // Sticky per-frame collision flag; frozen while paused, cleared at frame start.
   function automatic logic flag_next(input state_e st, input logic sof,
                                      input logic flag, input logic hit);
      logic nxt;
      if (st == ST_PAUSED) begin
         nxt = flag;
      end else if (sof) begin
         nxt = (st == ST_PLAY) && hit;
      end else if (st == ST_PLAY) begin
         nxt = flag || hit;
      end else begin
         nxt = flag;
      end
      return nxt;
   endfunction

   assign key5_edge_s = key5IsPressed && !key5_prev_q;
   assign keyp_edge_s = keyPauseIsPressed && !keyp_prev_q;
   assign score_sum_s = {2'b00, score_q}
                      + (bonus_q ? BONUS_W : 16'd0)
                      + (flip_q ? FLIPPER_W : 16'd0);

   // State register.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (key5_edge_s) state_d = ST_SERVE;
            else             state_d = state_q;
         end
         ST_SERVE: begin
            if (key5_edge_s) state_d = ST_PLAY;
            else             state_d = state_q;
         end
         ST_PLAY: begin
            if (startOfFrame && drain_q) state_d = ST_BALL_LOST;
            else if (keyp_edge_s)        state_d = ST_PAUSED;
            else                         state_d = state_q;
         end
         ST_PAUSED: begin
            if (keyp_edge_s) state_d = ST_PLAY;
            else             state_d = state_q;
         end
         ST_BALL_LOST: begin
            if (startOfFrame && (timer_q <= 6'd1))
               state_d = (balls_q != 2'd0) ? ST_SERVE : ST_GAME_OVER;
            else
               state_d = state_q;
         end
         ST_GAME_OVER: begin
            if (key5_edge_s) state_d = ST_SERVE;
            else             state_d = state_q;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output and datapath next values.
   always_comb begin
      pause_d    = (state_d != ST_PLAY);
      restart_d  = (state_d == ST_SERVE) && (state_q != ST_SERVE);
      launch_d   = (state_q == ST_SERVE) && (state_d == ST_PLAY);
      gameover_d = (state_d == ST_GAME_OVER);
      balls_d    = balls_q;
      score_d    = score_q;
      timer_d    = timer_q;
      drain_d    = flag_next(state_q, startOfFrame, drain_q, collisionSmileyDrain);
      bonus_d    = flag_next(state_q, startOfFrame, bonus_q, collisionSmileyBonus);
      flip_d     = flag_next(state_q, startOfFrame, flip_q, collisionSmileyFlipper);
      case (state_q)
         ST_IDLE, ST_GAME_OVER: begin
            if (key5_edge_s) begin
               balls_d = BALLS_W;
               score_d = 14'd0;
            end else begin
               balls_d = balls_q;
            end
         end
         ST_PLAY: begin
            if (startOfFrame) begin
               score_d = (score_sum_s >= SMAX_W) ? SMAX_W[13:0] : score_sum_s[13:0];
               if (drain_q) begin
                  balls_d = (balls_q != 2'd0) ? balls_q - 2'd1 : 2'd0;
                  timer_d = LOST_W;
               end else begin
                  timer_d = timer_q;
               end
            end else begin
               score_d = score_q;
            end
         end
         ST_BALL_LOST: begin
            if (startOfFrame) timer_d = (timer_q <= 6'd1) ? 6'd0 : timer_q - 6'd1;
            else              timer_d = timer_q;
         end
         default: timer_d = timer_q;
      endcase
   end

   // Registered outputs, collision flags, counters and key history.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         pause_q     <= 1'b1;
         restart_q   <= 1'b0;
         launch_q    <= 1'b0;
         gameover_q  <= 1'b0;
         balls_q     <= 2'd0;
         score_q     <= 14'd0;
         timer_q     <= 6'd0;
         drain_q     <= 1'b0;
         bonus_q     <= 1'b0;
         flip_q      <= 1'b0;
         key5_prev_q <= 1'b0;
         keyp_prev_q <= 1'b0;
      end else begin
         pause_q     <= pause_d;
         restart_q   <= restart_d;
         launch_q    <= launch_d;
         gameover_q  <= gameover_d;
         balls_q     <= balls_d;
         score_q     <= score_d;
         timer_q     <= timer_d;
         drain_q     <= drain_d;
         bonus_q     <= bonus_d;
         flip_q      <= flip_d;
         key5_prev_q <= key5IsPressed;
         keyp_prev_q <= keyPauseIsPressed;
      end
   end

   assign pause       = pause_q;
   assign ballRestart = restart_q;
   assign launch      = launch_q;
   assign ballsLeft   = balls_q;
   assign score       = score_q;
   assign gameOver    = gameover_q;
   assign state       = state_q;

endmodule

// File: tb/tb_pinball_game_ctrl.sv
// Directed bench for pinball_game_ctrl with hand-computed expectations.
module tb_pinball_game_ctrl;

   logic        clk = 1'b0;
   logic        resetN;
   logic        startOfFrame = 1'b0;
   logic        key5IsPressed = 1'b0;
   logic        keyPauseIsPressed = 1'b0;
   logic        collisionSmileyDrain = 1'b0;
   logic        collisionSmileyBonus = 1'b0;
   logic        collisionSmileyFlipper = 1'b0;
   logic        pause, ballRestart, launch, gameOver;
   logic [1:0]  ballsLeft;
   logic [13:0] score;
   logic [2:0]  state;

   int n_assert = 0;
   int n_fail   = 0;

   pinball_game_ctrl #(.LOST_FRAMES(2)) dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
      .key5IsPressed(key5IsPressed), .keyPauseIsPressed(keyPauseIsPressed),
      .collisionSmileyDrain(collisionSmileyDrain),
      .collisionSmileyBonus(collisionSmileyBonus),
      .collisionSmileyFlipper(collisionSmileyFlipper),
      .pause(pause), .ballRestart(ballRestart), .launch(launch),
      .ballsLeft(ballsLeft), .score(score), .gameOver(gameOver), .state(state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_k5();
      key5IsPressed = 1'b1; cyc(1); key5IsPressed = 1'b0;
   endtask

   task automatic pulse_kp();
      keyPauseIsPressed = 1'b1; cyc(1); keyPauseIsPressed = 1'b0;
   endtask

   task automatic frame();
      startOfFrame = 1'b1; cyc(1); startOfFrame = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_state"}, 32'(state), 32'd0);
      check({tag, "_pause"}, 32'(pause), 32'd1);
      check({tag, "_restart"}, 32'(ballRestart), 32'd0);
      check({tag, "_launch"}, 32'(launch), 32'd0);
      check({tag, "_balls"}, 32'(ballsLeft), 32'd0);
      check({tag, "_score"}, 32'(score), 32'd0);
      check({tag, "_gameover"}, 32'(gameOver), 32'd0);
   endtask

   initial begin
      resetN = 1'b1;
      #2 resetN = 1'b0;
      #1 check_reset("rst");
      @(posedge clk); @(posedge clk); #3 resetN = 1'b1;
      cyc(2);
      check("idle_hold", 32'(state), 32'd0);

      // Start game and serve.
      pulse_k5();
      check("serve_state", 32'(state), 32'd1);
      check("serve_restart", 32'(ballRestart), 32'd1);
      check("serve_balls", 32'(ballsLeft), 32'd3);
      cyc(1);
      check("serve_restart_drop", 32'(ballRestart), 32'd0);
      pulse_k5();
      check("play_state", 32'(state), 32'd2);
      check("play_launch", 32'(launch), 32'd1);
      check("play_pause", 32'(pause), 32'd0);
      cyc(1);
      check("play_launch_drop", 32'(launch), 32'd0);

      // Long bonus contact plus short flipper contact score once.
      frame();
      collisionSmileyBonus = 1'b1; cyc(100);
      collisionSmileyFlipper = 1'b1; cyc(3);
      collisionSmileyFlipper = 1'b0; cyc(397);
      collisionSmileyBonus = 1'b0; cyc(1);
      check("score_before_frame", 32'(score), 32'd0);
      frame();
      check("score_frame1", 32'(score), 32'd11);
      frame();
      check("score_frame2", 32'(score), 32'd11);

      // Pause keeps flags, blocks scoring; resume scores the held flag.
      collisionSmileyFlipper = 1'b1; cyc(1); collisionSmileyFlipper = 1'b0;
      pulse_kp();
      check("paused_state", 32'(state), 32'd3);
      check("paused_pause", 32'(pause), 32'd1);
      collisionSmileyBonus = 1'b1; cyc(2); collisionSmileyBonus = 1'b0;
      frame();
      check("paused_score", 32'(score), 32'd11);
      pulse_k5();
      check("paused_k5_ignored", 32'(state), 32'd3);
      cyc(1);
      pulse_kp();
      check("resume_state", 32'(state), 32'd2);
      check("resume_pause", 32'(pause), 32'd0);
      frame();
      check("resume_score", 32'(score), 32'd12);

      // Three drains with two-frame ball-lost windows.
      for (int i = 0; i < 3; i++) begin
         collisionSmileyDrain = 1'b1; cyc(1); collisionSmileyDrain = 1'b0;
         frame();
         check("lost_state", 32'(state), 32'd4);
         check("lost_balls", 32'(ballsLeft), 32'(2 - i));
         check("lost_pause", 32'(pause), 32'd1);
         frame();
         check("lost_hold", 32'(state), 32'd4);
         frame();
         if (i < 2) begin
            check("reserve_state", 32'(state), 32'd1);
            check("reserve_restart", 32'(ballRestart), 32'd1);
            pulse_k5();
            check("relaunch", 32'(launch), 32'd1);
         end else begin
            check("over_state", 32'(state), 32'd5);
            check("over_flag", 32'(gameOver), 32'd1);
            check("over_score", 32'(score), 32'd12);
         end
      end

      // Restart from game over.
      cyc(1);
      pulse_k5();
      check("restart_state", 32'(state), 32'd1);
      check("restart_score", 32'(score), 32'd0);
      check("restart_balls", 32'(ballsLeft), 32'd3);
      check("restart_gameover", 32'(gameOver), 32'd0);
      cyc(1);
      pulse_k5();
      check("restart_play", 32'(state), 32'd2);

      // Climb to 9995, then saturate.
      for (int i = 0; i < 999; i++) begin
         collisionSmileyBonus = 1'b1; cyc(1); collisionSmileyBonus = 1'b0;
         frame();
      end
      for (int i = 0; i < 5; i++) begin
         collisionSmileyFlipper = 1'b1; cyc(1); collisionSmileyFlipper = 1'b0;
         frame();
      end
      check("score_9995", 32'(score), 32'd9995);
      collisionSmileyBonus = 1'b1; cyc(1); collisionSmileyBonus = 1'b0;
      frame();
      check("score_sat1", 32'(score), 32'd9999);
      collisionSmileyBonus = 1'b1; cyc(1); collisionSmileyBonus = 1'b0;
      frame();
      check("score_sat2", 32'(score), 32'd9999);

      // Asynchronous reset in the middle of ball-lost.
      collisionSmileyDrain = 1'b1; cyc(1); collisionSmileyDrain = 1'b0;
      frame();
      check("mid_lost_state", 32'(state), 32'd4);
      #3 resetN = 1'b0;
      #1 check_reset("async_rst");

      // Key held through reset release counts as an edge.
      key5IsPressed = 1'b1;
      #2 resetN = 1'b1;
      cyc(1);
      check("held_key_state", 32'(state), 32'd1);
      check("held_key_balls", 32'(ballsLeft), 32'd3);
      key5IsPressed = 1'b0;
      cyc(1);
      pulse_kp();
      check("serve_pause_ignored", 32'(state), 32'd1);
      cyc(1);

      // Simultaneous edges in SERVE: only the launch is legal.
      key5IsPressed = 1'b1; keyPauseIsPressed = 1'b1;
      cyc(1);
      key5IsPressed = 1'b0; keyPauseIsPressed = 1'b0;
      check("dual_edge_state", 32'(state), 32'd2);
      check("dual_edge_pause", 32'(pause), 32'd0);
      check("dual_edge_launch", 32'(launch), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/pinball_game_ctrl.md
PINBALL_GAME_CTRL -- requirements
Module: pinball_game_ctrl

Interface
REQ-001 The block SHALL have parameter BALLS_PER_GAME, default 3: balls granted per game (1..3).
REQ-002 The block SHALL have parameter LOST_FRAMES, default 60: frames spent in BALL_LOST (1..63).
REQ-003 The block SHALL have parameter BONUS_POINTS, default 10: points per frame with a bonus hit.
REQ-004 The block SHALL have parameter FLIPPER_POINTS, default 1: points per frame with a flipper hit.
REQ-005 The block SHALL have parameter SCORE_MAX, default 9999: score saturation value.
REQ-006 The block SHALL have port clk, input, 1: system clock.
REQ-007 The block SHALL have port resetN, input, 1: asynchronous active-low reset.
REQ-008 The block SHALL have port startOfFrame, input, 1: one-cycle pulse per video frame.
REQ-009 The block SHALL have port key5IsPressed, input, 1: start/launch key level.
REQ-010 The block SHALL have port keyPauseIsPressed, input, 1: pause key level.
REQ-011 The block SHALL have port collisionSmileyDrain, input, 1: ball touches the drain region (per pixel).
REQ-012 The block SHALL have port collisionSmileyBonus, input, 1: ball touches a bonus target (per pixel).
REQ-013 The block SHALL have port collisionSmileyFlipper, input, 1: ball touches a flipper (per pixel).
REQ-014 The block SHALL have port pause, output, 1: freezes ball motion in the smiley block.
REQ-015 The block SHALL have port ballRestart, output, 1: one-cycle pulse that returns the ball to its launch position.
REQ-016 The block SHALL have port launch, output, 1: one-cycle pulse that launches the ball.
REQ-017 The block SHALL have port ballsLeft, output, 2: remaining balls, including the one in play.
REQ-018 The block SHALL have port score, output, 14: binary score.
REQ-019 The block SHALL have port gameOver, output, 1: high while in GAME_OVER.
REQ-020 The block SHALL have port state, output, 3: encoding IDLE=0, SERVE=1, PLAY=2, PAUSED=3, BALL_LOST=4, GAME_OVER=5.

Function
REQ-021 The block SHALL register both key inputs and act only on rising edges (previous 0, current 1); a held key SHALL produce exactly one event.
REQ-022 The block SHALL hold a sticky flag per collision input; each flag sets on any cycle its input is high in PLAY, and all flags clear on startOfFrame.
REQ-023 A collision asserted in the same cycle as startOfFrame SHALL belong to the new frame: the flag is cleared, then set.
REQ-024 On startOfFrame in PLAY, score SHALL add BONUS_POINTS if the bonus flag is set, plus FLIPPER_POINTS if the flipper flag is set, saturating at SCORE_MAX; it never wraps.
REQ-025 On startOfFrame in PLAY with the drain flag set, the FSM SHALL go to BALL_LOST after applying that frame's score, decrement ballsLeft, and load the frame timer with LOST_FRAMES.
REQ-026 IDLE -> SERVE SHALL occur on a key5 edge, loading ballsLeft=BALLS_PER_GAME and score=0.
REQ-027 SERVE -> PLAY SHALL occur on a key5 edge; launch pulses in the cycle after the edge is detected.
REQ-028 PLAY <-> PAUSED SHALL occur on a pause-key edge; pause-key edges SHALL be ignored in all other states.
REQ-029 In PAUSED, collision flags SHALL hold their value and no scoring SHALL occur.
REQ-030 In BALL_LOST, the timer SHALL decrement on each startOfFrame; when it reaches 0, the FSM SHALL go to SERVE if ballsLeft>0, otherwise to GAME_OVER.
REQ-031 GAME_OVER -> SERVE SHALL occur on a key5 edge, with score=0 and ballsLeft=BALLS_PER_GAME.
REQ-032 ballRestart SHALL pulse for one cycle on every entry into SERVE.
REQ-033 pause SHALL be 0 only in PLAY.
REQ-034 All outputs SHALL be registered; a state change SHALL be visible one cycle after the triggering edge or startOfFrame.
REQ-035 If a key5 edge and a pause-key edge arrive in the same cycle, the FSM SHALL evaluate only the transition legal for the current state.

Reset
REQ-036 Asynchronous resetN=0 SHALL force state=IDLE, pause=1, ballRestart=0, launch=0, ballsLeft=0, score=0, gameOver=0, all flags=0, timer=0, and key history=0, regardless of the current state.
REQ-037 After reset release, a key already held SHALL count as a rising edge on the first clock.

Verification
REQ-038 Reset, then a key5 pulse, then another key5 pulse -> states 0->1->2; ballRestart pulses once on entry to SERVE; launch pulses once; ballsLeft=3; pause falls to 0 in PLAY.
REQ-039 In PLAY, hold the bonus input for 500 cycles and the flipper input for 3 cycles within one frame -> score +11 at the next startOfFrame only.
REQ-040 Drain in a frame, repeated 3 times with LOST_FRAMES=2 -> ballsLeft 2,1,0; BALL_LOST lasts 2 frames each time; the third loss ends in GAME_OVER with gameOver=1.
REQ-041 Pause-key edge in PLAY, collisions applied, then a second pause-key edge -> PAUSED with pause=1 and score unchanged; on resume, the held flags score at the next frame.
REQ-042 Force score to 9995, then a bonus frame -> score=9999; another bonus frame -> score stays 9999.
REQ-043 Assert resetN=0 mid-BALL_LOST, asynchronous to clk -> all outputs reach their reset values before the next clock edge.
